// File: rtl/priority_inject_arbiter.sv
// priority_inject_arbiter
// Collects one-cycle priority samples from N_REQ sensors into per-slot
// pending registers and offers the highest-priority pending slot to a
// valid/ready consumer. Ties go to the first pending slot at or above the
// round-robin pointer. Every pending slot that loses a grant ages by +1.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     1 = accept new samples from prio_in
//   prio_in    N_REQ packed samples, slice i = [i*PRIO_W +: PRIO_W], 0 = none
//   out_valid  grant offer valid (OFFER state)
//   out_ready  consumer accepts offer
//   out_id     granted slot index
//   out_prio   granted slot priority
//   pending    per-slot pending flags
//   drop_cnt   saturating count of samples discarded on busy slots
//
// state  | meaning
// IDLE   | waiting for any pending slot
// SELECT | pick winner, register out_id/out_prio
// OFFER  | out_valid high, hold offer until out_ready
module priority_inject_arbiter #(
  parameter int N_REQ  = 4,
  parameter int PRIO_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [N_REQ*PRIO_W-1:0]    prio_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic [PRIO_W-1:0]          out_prio,
  output logic [N_REQ-1:0]           pending,
  output logic [7:0]                 drop_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  typedef logic [ID_W-1:0] id_t;
  typedef logic [ID_W:0]   idx_t;
  typedef enum logic [1:0] {IDLE, SELECT, OFFER} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    pend_q;
  logic [PRIO_W-1:0]   prio_q [N_REQ];
  id_t                 rr_ptr;

  logic                hs;
  logic [N_REQ-1:0]    rel, cap, drop;
  logic [3:0]          drop_num;
  logic [8:0]          drop_sum;
  logic [7:0]          drop_nxt;
  logic                win_found;
  id_t                 win_id;
  logic [PRIO_W-1:0]   win_prio;
  idx_t                idx;
  id_t                 rr_nxt;

  assign out_valid = (state_q == OFFER);
  assign hs        = out_valid && out_ready;
  assign pending   = pend_q;
  assign rr_nxt    = (out_id == id_t'(N_REQ - 1)) ? '0 : out_id + id_t'(1);

  // A slot being released on this edge may take a new sample immediately.
  always_comb begin
    rel      = '0;
    cap      = '0;
    drop     = '0;
    drop_num = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rel[i]  = hs && (out_id == id_t'(i));
      cap[i]  = enable && (prio_in[i*PRIO_W +: PRIO_W] != '0) && (!pend_q[i] || rel[i]);
      drop[i] = enable && (prio_in[i*PRIO_W +: PRIO_W] != '0) && pend_q[i] && !rel[i];
      drop_num = drop_num + {3'b000, drop[i]};
    end
    drop_sum = {1'b0, drop_cnt} + {5'b00000, drop_num};
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Scan from rr_ptr upward with wrap; strict '>' keeps the first of equals.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + idx_t'(k);
      if (idx >= idx_t'(N_REQ)) idx = idx - idx_t'(N_REQ);
      if (pend_q[idx[ID_W-1:0]] && (!win_found || prio_q[idx[ID_W-1:0]] > win_prio)) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
        win_prio  = prio_q[idx[ID_W-1:0]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pend_q) state_d = SELECT;
      SELECT:  state_d = OFFER;
      OFFER:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      rr_ptr   <= '0;
      out_id   <= '0;
      out_prio <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) prio_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      drop_cnt <= drop_nxt;
      if (state_q == SELECT) begin
        out_id   <= win_id;
        out_prio <= win_prio;
      end
      if (hs) rr_ptr <= rr_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs && pend_q[i] && !rel[i] && (prio_q[i] != '1))
          prio_q[i] <= prio_q[i] + 1'b1;
        if (rel[i]) pend_q[i] <= 1'b0;
        if (cap[i]) begin
          pend_q[i] <= 1'b1;
          prio_q[i] <= prio_in[i*PRIO_W +: PRIO_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_inject_arbiter.sv
module tb_priority_inject_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] prio_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [15:0] out_prio;
  logic [3:0]  pending;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  priority_inject_arbiter #(.N_REQ(4), .PRIO_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .prio_in   (prio_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_prio  (out_prio),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [15:0] s0, input logic [15:0] s1,
                        input logic [15:0] s2, input logic [15:0] s3);
    prio_in = {s3, s2, s1, s0};
    tick();
    prio_in = '0;
  endtask

  // Starting from IDLE with something pending and out_ready=1.
  task automatic grant(input string tag, input logic [1:0] exp_id, input logic [15:0] exp_prio);
    tick();
    chk({tag, "_sel_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_id"},    32'(out_id),    32'(exp_id));
    chk({tag, "_prio"},  32'(out_prio),  32'(exp_prio));
    tick();
    chk({tag, "_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; prio_in = '0;
    tick(); tick();
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_drop",    32'(drop_cnt),  32'd0);
    chk("rst_id",      32'(out_id),    32'd0);
    chk("rst_prio",    32'(out_prio),  32'd0);
    rst_n = 1'b1;
    tick();

    // single request, two-edge latency
    enable = 1'b1; out_ready = 1'b1;
    inject(16'h0, 16'h0, 16'h9C40, 16'h0);
    chk("single_pend", 32'(pending), 32'h4);
    chk("single_v0",   32'(out_valid), 32'd0);
    grant("single", 2'd2, 16'h9C40);
    chk("single_clear", 32'(pending), 32'h0);

    // max select with aging
    inject(16'd5, 16'd300, 16'd300, 16'd7);
    chk("max_pend", 32'(pending), 32'hF);
    grant("max1", 2'd1, 16'd300);
    grant("max2", 2'd2, 16'd301);
    grant("max3", 2'd3, 16'd9);
    grant("max4", 2'd0, 16'd8);
    chk("max_clear", 32'(pending), 32'h0);

    // tie broken by round-robin pointer
    inject(16'h0, 16'h20, 16'h0, 16'h0);
    grant("rr_pre", 2'd1, 16'h20);
    inject(16'd50, 16'h0, 16'h0, 16'd50);
    grant("tie1", 2'd3, 16'd50);
    grant("tie2", 2'd0, 16'd51);

    // release and capture on the same edge
    inject(16'h0, 16'h0500, 16'h0, 16'h0);
    tick(); tick();
    chk("rc_valid", 32'(out_valid), 32'd1);
    chk("rc_id",    32'(out_id),    32'd1);
    chk("rc_prio",  32'(out_prio),  32'h0500);
    inject(16'h0, 16'h0010, 16'h0, 16'h0);
    chk("rc_pend",  32'(pending),  32'h2);
    chk("rc_drop",  32'(drop_cnt), 32'd0);
    grant("rc_next", 2'd1, 16'h0010);

    // backpressure and drop saturation
    out_ready = 1'b0;
    inject(16'h0100, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_id",    32'(out_id),    32'd0);
    for (int i = 0; i < 3; i++) inject(16'h0200, 16'h0, 16'h0, 16'h0);
    chk("bp_drop3", 32'(drop_cnt), 32'd3);
    chk("bp_id_s",  32'(out_id),   32'd0);
    chk("bp_prio_s", 32'(out_prio), 32'h0100);
    enable = 1'b0;
    inject(16'h0300, 16'h0, 16'h0, 16'h0);
    chk("bp_dis_drop", 32'(drop_cnt), 32'd3);
    enable = 1'b1;
    for (int i = 0; i < 300; i++) inject(16'h0200, 16'h0, 16'h0, 16'h0);
    chk("bp_sat",   32'(drop_cnt), 32'd255);
    chk("bp_prio_h", 32'(out_prio), 32'h0100);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_pend",  32'(pending),   32'h0);
    chk("bp_rel_valid", 32'(out_valid), 32'd0);

    // reset in the middle of an offer
    out_ready = 1'b0;
    inject(16'h0, 16'h0, 16'h0777, 16'h0);
    tick(); tick();
    chk("mr_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid0", 32'(out_valid), 32'd0);
    chk("mr_pend0",  32'(pending),   32'h0);
    chk("mr_drop0",  32'(drop_cnt),  32'd0);
    chk("mr_id0",    32'(out_id),    32'd0);
    #1 rst_n = 1'b1;
    enable = 1'b0; out_ready = 1'b1;
    inject(16'h0, 16'h0, 16'h0, 16'h0123);
    chk("mr_nocap", 32'(pending), 32'h0);
    tick(); tick();
    chk("mr_idle", 32'(out_valid), 32'd0);
    chk("mr_drop", 32'(drop_cnt),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_inject_arbiter.md
PRIORITY_INJECT_ARBITER -- requirements
Module: priority_inject_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (priority sensors); 2..8.
REQ-002 Parameter PRIO_W, default 16: priority sample width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  high = accept new samples.
REQ-006 prio_in  input  N_REQ*PRIO_W  per-requester sensor output, slice i = bits [i*PRIO_W +: PRIO_W]; nonzero for one cycle = new request with that priority.
REQ-007 out_valid  output  1  grant offer valid.
REQ-008 out_ready  input  1  consumer accepts offer.
REQ-009 out_id  output  clog2(N_REQ)  index of granted requester.
REQ-010 out_prio  output  PRIO_W  priority of granted request.
REQ-011 pending  output  N_REQ  per-slot pending flags.
REQ-012 drop_cnt  output  8  dropped-sample counter.

Function
REQ-013 Per slot i: pend[i] bit plus prio register; pending output = pend.
REQ-014 Capture: enable=1, prio_in slice i nonzero, pend[i]=0 -> pend[i]=1, prio[i]=sample at that edge.
REQ-015 prio_in slice zero = no request; never captured, never counted.
REQ-016 Sample arriving while pend[i]=1 and slot not being released that edge -> discarded, drop_cnt +1, saturating at 255.
REQ-017 Sample arriving on the edge slot i is released by handshake -> captured; pend[i] stays 1, no drop.
REQ-018 enable=0: samples ignored, not counted; pending slots and in-flight offer continue normally.
REQ-019 FSM states IDLE, SELECT, OFFER.
REQ-020 IDLE: any pend=1 -> SELECT next edge; else stay.
REQ-021 SELECT: winner = pending slot with highest prio (unsigned); ties -> first pending index found scanning upward from rr_ptr, wrapping; register out_id/out_prio; -> OFFER.
REQ-022 OFFER: out_valid=1; out_id/out_prio held stable until handshake (out_valid & out_ready at edge).
REQ-023 Handshake: clear pend[winner] (unless REQ-017), rr_ptr = (winner+1) mod N_REQ, -> IDLE.
REQ-024 Aging: on each handshake, every other pending slot prio +1, saturating at all-ones.
REQ-025 Samples captured during OFFER do not alter current offer.
REQ-026 Latency: capture at edge t into empty arbiter -> SELECT after t+1, out_valid=1 after edge t+2.
REQ-027 out_valid low in IDLE and SELECT; minimum two cycles between back-to-back grants (IDLE, SELECT).
REQ-028 out_ready while out_valid=0 has no effect.

Reset
REQ-029 rst_n=0 asynchronously: FSM=IDLE, pend=0, all prio=0, rr_ptr=0, out_valid=0, out_id=0, out_prio=0, drop_cnt=0.
REQ-030 Reset during OFFER drops the offer; no handshake recorded; first post-reset edge obeys REQ-014 only.

Verification
REQ-031 Single: enable=1, slot 2 prio 0x9C40 for one cycle, out_ready=1 -> out_valid after 2 edges, out_id=2, out_prio=0x9C40, pending=0 after handshake.
REQ-032 Max select: slots 0..3 = 5,300,300,7 same cycle, out_ready=1 -> grant order 1 (300), 2 (301 aged), 3 (9), 0 (8).
REQ-033 Tie/rr: after grant of 1, slots 0 and 3 both 50 -> out_id=3 (rr_ptr=2 scan order), then 0.
REQ-034 Backpressure/drop: out_ready=0 holding slot 0 offer; slot 0 sample 3 more times -> out_id/out_prio stable, drop_cnt=3; 300 extra drops -> drop_cnt=255.
REQ-035 Release+capture same edge: slot 1 new sample 0x0010 on handshake edge of slot 1 -> pending[1]=1, next offer out_prio=0x0010, drop_cnt unchanged.
REQ-036 Reset mid-OFFER: rst_n low while out_valid=1 -> out_valid=0 immediately, pending=0, drop_cnt=0; enable=0 samples afterward -> no capture.
